// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the CPU's
//   instruction-fetch side (I) and load/store side (D). One access is in
//   flight at a time. The granted access drives the memory for LATENCY
//   cycles, then a one-cycle ready pulse returns the result. Ties alternate
//   round-robin, so neither side can starve.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   i_req/i_addr          fetch request (held until i_ready)
//   i_rdata/i_ready       fetched word (held) and completion pulse
//   d_req/d_we/d_addr/
//   d_wdata               load/store request (held until d_ready)
//   d_rdata/d_ready       load data (held) and completion pulse
//   mem_read/mem_write/
//   mem_addr/mem_wdata    memory command, driven from latched copies
//   mem_rdata             memory read data, valid in the last ACCESS cycle
//   busy                  high whenever the arbiter is not IDLE
module mem_port_arbiter #(
  parameter int WORD    = 16,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [WORD-1:0] i_addr,
  output logic [WORD-1:0] i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic [WORD-1:0] d_rdata,
  output logic            d_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy
);

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;  // 1 = D served last
  logic            gnt_q, gnt_d;                // 1 = D owns the access
  logic            we_q, we_d;
  logic [WORD-1:0] mem_addr_q, mem_addr_d;
  logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic [WORD-1:0] i_rdata_q, i_rdata_d;
  logic [WORD-1:0] d_rdata_q, d_rdata_d;
  logic            busy_q, busy_d;
  logic            sel;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    // On a tie the side that did not win last time goes first.
    sel          = (i_req && d_req) ? ~last_grant_q : d_req;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d      = ACCESS;
          cnt_d        = CNT_INIT;
          last_grant_d = sel;
          gnt_d        = sel;
          we_d         = sel & d_we;
          mem_addr_d   = sel ? d_addr : i_addr;
          mem_wdata_d  = d_wdata;
          // Strobes are registered here so they appear in the first ACCESS cycle.
          mem_read_d   = ~(sel & d_we);
          mem_write_d  = sel & d_we;
          busy_d       = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (gnt_q) begin
            d_ready_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset abandons any access in flight: strobes and ready drop at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY 2 and 1) under random
// requesters, a behavioural memory, and a timeline reference model. Each
// access granted in cycle g strobes in g+1..g+L, readies in g+L+1 and frees
// the port in g+L+2. Ties go to the side that was not served last.
module tb_mem_port_arbiter;

  localparam int NCYC = 1600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ival(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h6A15;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gl
    localparam int L = (g == 0) ? 2 : 1;

    logic        rst_n = 1'b0;
    logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
    logic [15:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
    logic [15:0] irdata, drdata, maddr, mwdata;
    logic        irdy, drdy, mrd, mwr, bsy;

    mem_port_arbiter #(.WORD(16), .LATENCY(L)) dut (
      .clk(clk), .reset_n(rst_n),
      .i_req(ireq), .i_addr(iaddr), .i_rdata(irdata), .i_ready(irdy),
      .d_req(dreq), .d_we(dwe), .d_addr(daddr), .d_wdata(dwdata),
      .d_rdata(drdata), .d_ready(drdy),
      .mem_read(mrd), .mem_write(mwr), .mem_addr(maddr), .mem_wdata(mwdata),
      .mem_rdata(mrdata), .busy(bsy)
    );

    logic [15:0] wr_mem  [int];   // environment memory seen by the DUT
    logic [15:0] ref_mem [int];   // model's view of stored data
    int          cyc = 0;
    int          g_cyc = -100;    // cycle in which the current access was granted
    bit          armed = 0, m_zero = 1;
    bit          m_side = 0, m_we = 0, m_last = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_ir = '0, m_dr = '0;

    initial begin
      wr_mem[16]  = 16'h6A05;
      ref_mem[16] = 16'h6A05;
    end

    always @(negedge clk) begin
      int  ph;
      int  mode;
      bit  side;
      logic [15:0] rv;
      mode = (cyc >= 600 && cyc < 950) ? 1 : 0;   // 1: both sides request nonstop
      ph   = cyc - g_cyc;

      // environment memory
      if (mwr) wr_mem[int'(maddr)] = mwdata;
      if (mrd) mrdata = wr_mem.exists(int'(maddr)) ? wr_mem[int'(maddr)] : ival(maddr);
      else     mrdata = 16'h0;

      // compare this cycle's outputs with the timeline
      if (armed) begin
        chk($sformatf("L%0d busy", L),    32'(bsy),  32'(ph >= 1 && ph <= L + 1));
        chk($sformatf("L%0d mem_read", L),  32'(mrd), 32'(ph >= 1 && ph <= L && !m_we));
        chk($sformatf("L%0d mem_write", L), 32'(mwr), 32'(ph >= 1 && ph <= L && m_we));
        chk($sformatf("L%0d i_ready", L), 32'(irdy), 32'(ph == L + 1 && !m_side));
        chk($sformatf("L%0d d_ready", L), 32'(drdy), 32'(ph == L + 1 && m_side));
        chk($sformatf("L%0d i_rdata", L), 32'(irdata), 32'(m_ir));
        chk($sformatf("L%0d d_rdata", L), 32'(drdata), 32'(m_dr));
        if (ph >= 1 && ph <= L) begin
          chk($sformatf("L%0d mem_addr", L), 32'(maddr), 32'(m_addr));
          if (m_we) chk($sformatf("L%0d mem_wdata", L), 32'(mwdata), 32'(m_wdata));
        end
        if (m_zero) begin
          chk($sformatf("L%0d rst addr", L),  32'(maddr),  32'h0);
          chk($sformatf("L%0d rst wdata", L), 32'(mwdata), 32'h0);
        end
      end

      // requesters: drop (or renew) after ready, otherwise maybe raise
      if (irdy && !(mode == 1 || $urandom_range(0, 3) == 0)) ireq = 1'b0;
      else if (irdy || (!ireq && (mode == 1 || $urandom_range(0, 2) == 0))) begin
        ireq  = 1'b1;
        iaddr = 16'($urandom_range(0, 31));
      end
      if (drdy && !(mode == 1 || $urandom_range(0, 3) == 0)) dreq = 1'b0;
      else if (drdy || (!dreq && (mode == 1 || $urandom_range(0, 2) == 0))) begin
        dreq   = 1'b1;
        dwe    = 1'($urandom_range(0, 1));
        daddr  = 16'($urandom_range(0, 31));
        dwdata = 16'($urandom);
      end
      rst_n = !(cyc < 3 || (mode == 0 && $urandom_range(0, 120) == 0));

      // advance the model across the coming edge
      if (!rst_n) begin
        // an abandoned store has already strobed the memory
        if (armed && ph >= 1 && ph <= L && m_we) ref_mem[int'(m_addr)] = m_wdata;
        armed  = 1;
        g_cyc  = -100;
        m_last = 0; m_side = 0; m_we = 0;
        m_ir   = '0; m_dr = '0;
        m_zero = 1;
      end else if (armed) begin
        if (ph >= L + 2 && (ireq || dreq)) begin
          side    = (ireq && dreq) ? !m_last : dreq;
          g_cyc   = cyc;
          m_side  = side;
          m_last  = side;
          m_we    = side && dwe;
          m_addr  = side ? daddr : iaddr;
          m_wdata = dwdata;
          m_zero  = 0;
        end else if (ph == L) begin
          rv = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : ival(m_addr);
          if (!m_side)   m_ir = rv;
          else if (m_we) ref_mem[int'(m_addr)] = m_wdata;
          else           m_dr = rv;
        end
      end
      cyc++;
    end
  end

  initial begin
    repeat (NCYC) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
